serial_frame_receiver: RTL and testbench

Serial-in, parallel-out frame receiver that sits at the far end of the serial line driven by the register's shift output. It detects a start bit, shifts in WIDTH data bits in a per-frame selectable order (LSB-first or MSB-first), checks the stop bit, and presents each completed word on a valid/ready output with a one-word holding buffer. Framing errors and overruns are flagged as single-cycle pulses.

---
 rtl/serial_pkg.sv | 12 +
 rtl/sipo_shift_reg.sv | 34 +++
 rtl/serial_frame_receiver.sv | 157 +++++++++++++++
 tb/tb_serial_frame_receiver.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: receiver FSM encoding and bit-order codes
// that the transmitter side uses as well.
package serial_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in/parallel-out shift datapath; the bit order is chosen per shift by dir.
module sipo_shift_reg
    import serial_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic             dir,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // Shift register: MSB-first enters at bit 0, LSB-first enters at the top.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (shift_en) begin
            if (dir == DIR_MSB_FIRST) begin
                r_q <= {r_q[WIDTH-2:0], sin};
            end else begin
                r_q <= {sin, r_q[WIDTH-1:1]};
            end
        end else begin
            r_q <= r_q;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/serial_frame_receiver.sv
// Start/data/stop frame receiver with per-frame bit order, one-word output buffer
// on a valid/ready handshake, and single-cycle framing-error/overrun pulses.
module serial_frame_receiver
    import serial_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_en,
    input  logic             ser_in,
    input  logic             dir,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic             r_dir_q;
    logic [CW-1:0]    r_bit_cnt;
    logic [WIDTH-1:0] w_shreg;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_frame_err;
    logic             r_overrun;

    logic             w_start;
    logic             w_shift_en;
    logic             w_last_bit;
    logic             w_commit;
    logic             w_drop;
    logic             w_bad_stop;
    logic             w_drain;

    sipo_shift_reg #(.WIDTH(WIDTH)) u_shreg (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (w_shift_en),
        .dir      (r_dir_q),
        .sin      (ser_in),
        .q        (w_shreg)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; everything advances only on bit_en.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bit_en && !ser_in) begin
                    w_next_state = ST_DATA;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (bit_en && w_last_bit) begin
                    w_next_state = ST_STOP;
                end else begin
                    w_next_state = ST_DATA;
                end
            end
            ST_STOP: begin
                if (bit_en) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_STOP;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Per-cycle control decodes for the datapath, buffer and flags.
    always_comb begin
        w_start    = 1'b0;
        w_shift_en = 1'b0;
        w_commit   = 1'b0;
        w_drop     = 1'b0;
        w_bad_stop = 1'b0;
        w_drain    = r_valid & ready;
        w_last_bit = (r_bit_cnt == CW'(WIDTH - 1));
        case (r_state)
            ST_IDLE: begin
                w_start = bit_en & ~ser_in;
            end
            ST_DATA: begin
                w_shift_en = bit_en;
            end
            ST_STOP: begin
                w_commit   = bit_en & ser_in & (~r_valid | ready);
                w_drop     = bit_en & ser_in & r_valid & ~ready;
                w_bad_stop = bit_en & ~ser_in;
            end
            default: begin
                w_start = 1'b0;
            end
        endcase
    end

    // Bit order capture and data-bit counter; the counter is cleared at each start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dir_q   <= DIR_LSB_FIRST;
            r_bit_cnt <= '0;
        end else if (w_start) begin
            r_dir_q   <= dir;
            r_bit_cnt <= '0;
        end else if (w_shift_en) begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
        end else begin
            r_bit_cnt <= r_bit_cnt;
        end
    end

    // Holding buffer and one-cycle error pulses; a commit wins over a drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_bad_stop;
            r_overrun   <= w_drop;
            if (w_commit) begin
                r_data  <= w_shreg;
                r_valid <= 1'b1;
            end else if (w_drain) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= r_valid;
            end
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign busy      = (r_state != ST_IDLE);
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Bench for serial_frame_receiver: frame-level reference model compared every cycle,
// directed literal checks from the test plan, then randomized frames.
module tb_serial_frame_receiver;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         bit_en = 1'b0;
    logic         ser_in = 1'b1;
    logic         dir = 1'b0;
    logic         ready = 1'b0;
    logic [W-1:0] data;
    logic         valid;
    logic         busy;
    logic         frame_err;
    logic         overrun;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    bit rand_ready = 1'b0;

    // Reference model: frame position -1 = idle, 0..W-1 = data bit index, W = stop bit.
    int           m_pos = -1;
    logic         m_dir = 1'b0;
    int           m_word = 0;
    logic [W-1:0] m_data = '0;
    logic         m_valid = 1'b0;
    logic         m_busy = 1'b0;
    logic         m_ferr = 1'b0;
    logic         m_ovr = 1'b0;

    serial_frame_receiver #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_en    (bit_en),
        .ser_in    (ser_in),
        .dir       (dir),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bit drain;
        bit commit;
        if (!rst_n) begin
            m_pos = -1; m_dir = 1'b0; m_word = 0; m_data = '0;
            m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        end else begin
            drain  = m_valid && ready;
            commit = 1'b0;
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
            if (bit_en) begin
                if (m_pos < 0) begin
                    if (ser_in == 1'b0) begin
                        m_pos = 0; m_dir = dir; m_word = 0;
                    end
                end else if (m_pos < W) begin
                    m_word = m_word + (int'(ser_in) << (m_dir ? (W - 1 - m_pos) : m_pos));
                    m_pos = m_pos + 1;
                end else begin
                    m_pos = -1;
                    if (ser_in) begin
                        if (!m_valid || drain) begin
                            m_data = m_word[W-1:0]; m_valid = 1'b1; commit = 1'b1;
                        end else begin
                            m_ovr = 1'b1;
                        end
                    end else begin
                        m_ferr = 1'b1;
                    end
                end
            end
            if (!commit && drain) m_valid = 1'b0;
        end
        m_busy = (m_pos >= 0);
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("valid", int'(valid), int'(m_valid));
            check("busy", int'(busy), int'(m_busy));
            check("frame_err", int'(frame_err), int'(m_ferr));
            check("overrun", int'(overrun), int'(m_ovr));
            if (m_valid) check("data", int'(data), int'(m_data));
        end
    end

    // One frame; each bit lasts 'per' cycles with bit_en on the last. stop_ready>=0 forces ready in the stop bit.
    task automatic send_frame(input logic [W-1:0] w, input logic d, input logic stopb,
                              input int per, input int stop_ready);
        logic [W+1:0] bits;
        bits[0] = 1'b0;
        for (int i = 0; i < W; i++) bits[i+1] = d ? w[W-1-i] : w[i];
        bits[W+1] = stopb;
        for (int b = 0; b < W + 2; b++) begin
            for (int k = 0; k < per; k++) begin
                @(negedge clk);
                ser_in = bits[b];
                dir    = d;
                bit_en = (k == per - 1);
                if (rand_ready) ready = 1'($urandom_range(0, 1));
                if (b == W + 1 && stop_ready >= 0) ready = (stop_ready != 0);
            end
        end
        @(negedge clk);
        bit_en = 1'b0;
        ser_in = 1'b1;
        if (rand_ready) ready = 1'($urandom_range(0, 1));
    endtask

    initial begin
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        check("reset valid", int'(valid), 0);
        check("reset busy", int'(busy), 0);
        check("reset data", int'(data), 0);

        // LSB-first 0,1,0,1,1,1 -> 4'hD
        ready = 1'b1;
        send_frame(4'hD, 1'b0, 1'b1, 1, -1);
        check("lsb data", int'(data), 32'hD);
        check("lsb valid", int'(valid), 1);
        check("model lsb", int'(m_data), 32'hD);
        @(negedge clk);
        check("lsb valid drops", int'(valid), 0);

        // MSB-first, same line pattern -> 4'hB; then with sparse bit_en
        send_frame(4'hB, 1'b1, 1'b1, 1, -1);
        check("msb data", int'(data), 32'hB);
        check("model msb", int'(m_data), 32'hB);
        send_frame(4'hB, 1'b1, 1'b1, 3, -1);
        check("msb slow data", int'(data), 32'hB);

        // Bad stop bit
        send_frame(4'hF, 1'b0, 1'b0, 1, -1);
        check("ferr pulse", int'(frame_err), 1);
        check("ferr valid", int'(valid), 0);
        @(negedge clk);
        check("ferr one cycle", int'(frame_err), 0);
        send_frame(4'h6, 1'b0, 1'b1, 1, -1);
        check("after ferr data", int'(data), 32'h6);

        // Overrun with ready low
        @(negedge clk); ready = 1'b0;
        send_frame(4'h3, 1'b0, 1'b1, 1, -1);
        send_frame(4'hC, 1'b0, 1'b1, 1, -1);
        check("ovr data held", int'(data), 32'h3);
        check("ovr pulse", int'(overrun), 1);
        check("model ovr", int'(m_ovr), 1);
        ready = 1'b1;
        @(negedge clk);
        check("ovr drained", int'(valid), 0);

        // Drain in the stop-bit cycle
        ready = 1'b0;
        send_frame(4'h3, 1'b0, 1'b1, 1, -1);
        send_frame(4'hC, 1'b0, 1'b1, 1, 1);
        ready = 1'b0;
        check("drain data", int'(data), 32'hC);
        check("drain valid", int'(valid), 1);
        check("drain no ovr", int'(overrun), 0);

        // Reset mid-frame with a word pending
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            bit_en = 1'b1;
            ser_in = (b == 0) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        bit_en = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst busy", int'(busy), 0);
        check("rst valid", int'(valid), 0);
        ready = 1'b1;
        send_frame(4'h9, 1'b0, 1'b1, 1, -1);
        check("post rst data", int'(data), 32'h9);

        // Randomized frames, bit_en density, ready, stop errors, idle gaps and resets
        rand_ready = 1'b1;
        for (int f = 0; f < 80; f++) begin
            send_frame(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 5) != 0), $urandom_range(1, 3), -1);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                bit_en = 1'($urandom_range(0, 1));
                ser_in = 1'b1;
                ready  = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 19) == 0) begin
                @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        bit_en = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
